// File: rtl/alu_issue_ctrl_if.sv
// Instruction and result handshake channels between the issue controller
// and its producer/consumer.
interface alu_issue_ctrl_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs1;
  logic [1:0] instr_rs2;
  logic       instr_imm_en;
  logic [7:0] instr_imm;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_rd;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm,
    input  instr_ready,
    input  res_valid, res_data, res_rd,
    output res_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm_en, instr_imm,
    output instr_ready,
    output res_valid, res_data, res_rd,
    input  res_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Serialising issue/writeback controller for an external 8-bit ALU with a
// 4x8 register file (r0 reads as zero).
module alu_issue_ctrl #(
  parameter int NREGS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave ifc,
  output logic [7:0]      o_alu_a,
  output logic [7:0]      o_alu_b,
  output logic [2:0]      o_alu_op,
  input  logic [7:0]      i_alu_out,
  output logic [7:0]      o_retired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_instr_ready;
  logic       r_res_valid;
  logic [7:0] r_rf [NREGS];
  logic [7:0] r_alu_a;
  logic [7:0] r_alu_b;
  logic [2:0] r_alu_op;
  logic [1:0] r_rd;
  logic [7:0] r_res_data;
  logic [1:0] r_res_rd;
  logic [7:0] r_retired;
  logic       w_accept;
  logic       w_retire;

  function automatic logic [7:0] sel_b(input logic imm_en, input logic [7:0] imm,
                                       input logic [7:0] reg_val);
    if (imm_en) begin
      return imm;
    end else begin
      return reg_val;
    end
  endfunction

  assign w_accept = (r_state == S_IDLE) && ifc.instr_valid;
  assign w_retire = (r_state == S_RESP) && ifc.res_ready;

  // State register plus registered handshake flags decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_instr_ready <= 1'b1;
      r_res_valid   <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_instr_ready <= (w_next == S_IDLE);
      r_res_valid   <= (w_next == S_RESP);
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (ifc.instr_valid) begin
          w_next = S_EXEC;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_EXEC: w_next = S_RESP;
      S_RESP: begin
        if (ifc.res_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_RESP;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, writeback and retire counter; r_rf[0] is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_rf[i] <= 8'h00;
      end
      r_alu_a    <= 8'h00;
      r_alu_b    <= 8'h00;
      r_alu_op   <= 3'b000;
      r_rd       <= 2'd0;
      r_res_data <= 8'h00;
      r_res_rd   <= 2'd0;
      r_retired  <= 8'h00;
    end else begin
      if (w_accept) begin
        r_alu_op <= ifc.instr_op;
        r_alu_a  <= r_rf[ifc.instr_rs1];
        r_alu_b  <= sel_b(ifc.instr_imm_en, ifc.instr_imm, r_rf[ifc.instr_rs2]);
        r_rd     <= ifc.instr_rd;
      end
      if (r_state == S_EXEC) begin
        r_res_data <= i_alu_out;
        r_res_rd   <= r_rd;
        if (r_rd != 2'd0) begin
          r_rf[r_rd] <= i_alu_out;
        end
      end
      if (w_retire) begin
        r_retired <= r_retired + 8'd1;
      end
    end
  end

  assign ifc.instr_ready = r_instr_ready;
  assign ifc.res_valid   = r_res_valid;
  assign ifc.res_data    = r_res_data;
  assign ifc.res_rd      = r_res_rd;
  assign o_alu_a         = r_alu_a;
  assign o_alu_b         = r_alu_b;
  assign o_alu_op        = r_alu_op;
  assign o_retired       = r_retired;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random
// instructions scored against an architectural register-file model.
module tb_alu_issue_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_out;
  logic [7:0] retired;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] mrf [4];
  logic [7:0] mret;

  alu_issue_ctrl_if u_if ();

  alu_issue_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ifc       (u_if),
    .o_alu_a   (alu_a),
    .o_alu_b   (alu_b),
    .o_alu_op  (alu_op),
    .i_alu_out (alu_out),
    .o_retired (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ~a;
      3'd6:    return a << b[2:0];
      default: return a >> b[2:0];
    endcase
  endfunction

  // The external ALU the controller drives
  always_comb alu_out = ref_alu(alu_op, alu_a, alu_b);

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
    mret = 8'h00;
  endtask

  task automatic chk_reset();
    chk("rst_instr_ready", {7'd0, u_if.instr_ready}, 8'h01);
    chk("rst_res_valid", {7'd0, u_if.res_valid}, 8'h00);
    chk("rst_res_data", u_if.res_data, 8'h00);
    chk("rst_res_rd", {6'd0, u_if.res_rd}, 8'h00);
    chk("rst_alu_a", alu_a, 8'h00);
    chk("rst_alu_b", alu_b, 8'h00);
    chk("rst_alu_op", {5'd0, alu_op}, 8'h00);
    chk("rst_retired", retired, 8'h00);
  endtask

  task automatic drive_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm);
    u_if.instr_valid  = 1'b1;
    u_if.instr_op     = op;
    u_if.instr_rd     = rd;
    u_if.instr_rs1    = rs1;
    u_if.instr_rs2    = rs2;
    u_if.instr_imm_en = imm_en;
    u_if.instr_imm    = imm;
  endtask

  task automatic scramble_instr(input logic keep_valid);
    u_if.instr_valid  = keep_valid;
    u_if.instr_op     = 3'($urandom);
    u_if.instr_rd     = 2'($urandom);
    u_if.instr_rs1    = 2'($urandom);
    u_if.instr_rs2    = 2'($urandom);
    u_if.instr_imm_en = 1'($urandom);
    u_if.instr_imm    = 8'($urandom);
  endtask

  // Full instruction: accept, EXEC, RESP with `stall` backpressure cycles, handshake
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                       input logic [1:0] rs2, input logic imm_en, input logic [7:0] imm,
                       input int stall, input logic hold_valid, output logic [7:0] got);
    logic [7:0] ea, eb, er;
    ea = mrf[rs1];
    eb = imm_en ? imm : mrf[rs2];
    er = ref_alu(op, ea, eb);
    u_if.res_ready = 1'b0;
    drive_instr(op, rd, rs1, rs2, imm_en, imm);
    chk("idle_ready", {7'd0, u_if.instr_ready}, 8'h01);
    @(posedge clk); #1;
    scramble_instr(hold_valid);
    chk("exec_ready", {7'd0, u_if.instr_ready}, 8'h00);
    chk("exec_res_valid", {7'd0, u_if.res_valid}, 8'h00);
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_op", {5'd0, alu_op}, {5'd0, op});
    @(posedge clk); #1;
    chk("resp_valid", {7'd0, u_if.res_valid}, 8'h01);
    chk("resp_data", u_if.res_data, er);
    chk("resp_rd", {6'd0, u_if.res_rd}, {6'd0, rd});
    got = u_if.res_data;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      scramble_instr(hold_valid);
      chk("stall_valid", {7'd0, u_if.res_valid}, 8'h01);
      chk("stall_data", u_if.res_data, er);
      chk("stall_ready", {7'd0, u_if.instr_ready}, 8'h00);
    end
    u_if.res_ready = 1'b1;
    @(posedge clk); #1;
    u_if.res_ready   = 1'b0;
    u_if.instr_valid = 1'b0;
    mret = mret + 8'd1;
    if (rd != 2'd0) mrf[rd] = er;
    chk("post_res_valid", {7'd0, u_if.res_valid}, 8'h00);
    chk("post_ready", {7'd0, u_if.instr_ready}, 8'h01);
    chk("post_retired", retired, mret);
  endtask

  // Accept an instruction, then pull reset after `edges` more clock edges (1 = EXEC, 2 = RESP)
  task automatic start_and_reset(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic imm_en, input logic [7:0] imm, input int edges);
    logic exp_v;
    exp_v = (edges >= 2);
    u_if.res_ready = 1'b0;
    drive_instr(op, rd, rs1, 2'd0, imm_en, imm);
    @(posedge clk); #1;
    u_if.instr_valid = 1'b0;
    for (int i = 1; i < edges; i++) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_valid", {7'd0, u_if.res_valid}, {7'd0, exp_v});
    #2 rst_n = 1'b0;
    #1;
    chk_reset();
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", {7'd0, u_if.instr_ready}, 8'h01);
  endtask

  initial begin
    logic [7:0] got;
    rst_n            = 1'b0;
    u_if.instr_valid = 1'b0;
    u_if.res_ready   = 1'b0;
    scramble_instr(1'b0);
    model_reset();
    #12;
    chk_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_ready", {7'd0, u_if.instr_ready}, 8'h01);

    issue(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 0, 1'b0, got);
    chk("load_imm", got, 8'h05);
    issue(3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 8'h00, 0, 1'b0, got);
    chk("sub_neg", got, 8'hFB);

    issue(3'd3, 2'd3, 2'd2, 2'd0, 1'b1, 8'h00, 5, 1'b1, got);
    chk("backpressure", got, 8'hFB);

    issue(3'd0, 2'd0, 2'd0, 2'd0, 1'b1, 8'h33, 0, 1'b0, got);
    chk("r0_write_res", got, 8'h33);
    issue(3'd3, 2'd3, 2'd0, 2'd0, 1'b1, 8'h00, 0, 1'b0, got);
    chk("r0_reads_zero", got, 8'h00);

    issue(3'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h81, 0, 1'b0, got);
    issue(3'd6, 2'd2, 2'd1, 2'd0, 1'b1, 8'h09, 0, 1'b0, got);
    chk("shl_mask", got, 8'h02);
    issue(3'd7, 2'd2, 2'd1, 2'd0, 1'b1, 8'h09, 0, 1'b0, got);
    chk("shr_mask", got, 8'h40);

    start_and_reset(3'd0, 2'd1, 2'd0, 1'b1, 8'h55, 2);
    issue(3'd0, 2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 0, 1'b0, got);
    chk("r1_cleared", got, 8'h00);
    start_and_reset(3'd0, 2'd1, 2'd0, 1'b1, 8'h00, 1);

    for (int n = 0; n < 256; n++) begin
      issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
            8'($urandom), int'($urandom_range(0, 2)), 1'($urandom), got);
    end
    chk("retired_wrap", retired, 8'h00);

    for (int n = 0; n < 3; n++) begin
      issue(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
            8'($urandom), 0, 1'b0, got);
    end
    chk("retired_three", retired, 8'h03);
    start_and_reset(3'd0, 2'd3, 2'd0, 1'b1, 8'h77, 1);
    chk("retired_cleared", retired, 8'h00);
    issue(3'd0, 2'd0, 2'd3, 2'd0, 1'b1, 8'h00, 0, 1'b0, got);
    chk("r3_no_writeback", got, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
